apb_master_bridge: RTL and testbench

APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

---
 rtl/apb_master_bridge_if.sv | 42 ++++
 rtl/apb_master_bridge.sv | 136 +++++++++++++
 tb/tb_apb_master_bridge.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_master_bridge_if.sv
// Bus bundle between the request/response client, the bridge and the APB slaves.
// "master" is the bridge's view; "slave" is the environment's view (requester plus APB slave).
interface apb_master_bridge_if #(
  parameter int NO_OF_SLAVES   = 4,
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int WAIT_CNT_WIDTH = 8
);
  logic                      I_REQ_VALID;
  logic                      O_REQ_READY;
  logic                      I_REQ_WRITE;
  logic [ADDR_WIDTH-1:0]     I_REQ_ADDR;
  logic [DATA_WIDTH-1:0]     I_REQ_WDATA;
  logic                      O_RSP_VALID;
  logic                      I_RSP_READY;
  logic [DATA_WIDTH-1:0]     O_RSP_RDATA;
  logic                      O_RSP_ERR;
  logic [WAIT_CNT_WIDTH-1:0] O_RSP_WAIT_CNT;

  logic [NO_OF_SLAVES-1:0]   O_PSEL;
  logic                      O_PENABLE;
  logic                      O_PWRITE;
  logic [ADDR_WIDTH-1:0]     O_PADDR;
  logic [DATA_WIDTH-1:0]     O_PWDATA;
  logic                      I_PREADY;
  logic                      I_PSLVERR;
  logic [DATA_WIDTH-1:0]     I_PRDATA;

  modport master (
    input  I_REQ_VALID, I_REQ_WRITE, I_REQ_ADDR, I_REQ_WDATA, I_RSP_READY,
    output O_REQ_READY, O_RSP_VALID, O_RSP_RDATA, O_RSP_ERR, O_RSP_WAIT_CNT,
    output O_PSEL, O_PENABLE, O_PWRITE, O_PADDR, O_PWDATA,
    input  I_PREADY, I_PSLVERR, I_PRDATA
  );

  modport slave (
    output I_REQ_VALID, I_REQ_WRITE, I_REQ_ADDR, I_REQ_WDATA, I_RSP_READY,
    input  O_REQ_READY, O_RSP_VALID, O_RSP_RDATA, O_RSP_ERR, O_RSP_WAIT_CNT,
    input  O_PSEL, O_PENABLE, O_PWRITE, O_PADDR, O_PWDATA,
    output I_PREADY, I_PSLVERR, I_PRDATA
  );
endinterface

// File: rtl/apb_master_bridge.sv
// Single-outstanding request/response to APB master bridge with address-MSB slave decode,
// wait-state counting and decode-error responses. Interface parameters must match the module's.
module apb_master_bridge #(
  parameter int NO_OF_SLAVES   = 4,
  parameter int SLAVE_ID_WIDTH = 2,
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int WAIT_CNT_WIDTH = 8
) (
  input  logic                 I_PCLK,
  input  logic                 I_PRESETN,
  apb_master_bridge_if.master  bus
);

  typedef enum logic [3:0] {
    IDLE   = 4'b0001,
    SETUP  = 4'b0010,
    ACCESS = 4'b0100,
    RESP   = 4'b1000
  } state_t;

  localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_MAX = '1;

  state_t                    state_q;
  logic [NO_OF_SLAVES-1:0]   psel_q;
  logic                      penable_q;
  logic                      pwrite_q;
  logic [ADDR_WIDTH-1:0]     paddr_q;
  logic [DATA_WIDTH-1:0]     pwdata_q;
  logic                      rsp_valid_q;
  logic [DATA_WIDTH-1:0]     rsp_rdata_q;
  logic                      rsp_err_q;
  logic [WAIT_CNT_WIDTH-1:0] wait_cnt_q;
  logic [WAIT_CNT_WIDTH-1:0] wait_cnt_d;

  logic [SLAVE_ID_WIDTH-1:0] slave_idx;
  logic                      decode_err;
  logic [NO_OF_SLAVES-1:0]   psel_onehot;

  assign slave_idx  = bus.I_REQ_ADDR[ADDR_WIDTH-1 -: SLAVE_ID_WIDTH];
  assign decode_err = (int'(slave_idx) >= NO_OF_SLAVES);

  generate
    for (genvar gi = 0; gi < NO_OF_SLAVES; gi++) begin : g_psel_dec
      assign psel_onehot[gi] = (int'(slave_idx) == gi);
    end
  endgenerate

  assign wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q
                                               : wait_cnt_q + WAIT_CNT_WIDTH'(1);

  always_ff @(posedge I_PCLK or negedge I_PRESETN) begin
    if (!I_PRESETN) begin
      state_q     <= IDLE;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      wait_cnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.I_REQ_VALID) begin
            wait_cnt_q  <= '0;
            rsp_rdata_q <= '0;
            if (decode_err) begin
              // No APB traffic for an unmapped slave; answer with an error directly.
              rsp_err_q   <= 1'b1;
              rsp_valid_q <= 1'b1;
              state_q     <= RESP;
            end else begin
              rsp_err_q   <= 1'b0;
              psel_q      <= psel_onehot;
              penable_q   <= 1'b0;
              pwrite_q    <= bus.I_REQ_WRITE;
              paddr_q     <= bus.I_REQ_ADDR;
              pwdata_q    <= bus.I_REQ_WDATA;
              state_q     <= SETUP;
            end
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          if (bus.I_PREADY) begin
            rsp_rdata_q <= pwrite_q ? '0 : bus.I_PRDATA;
            rsp_err_q   <= bus.I_PSLVERR;
            rsp_valid_q <= 1'b1;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            state_q     <= RESP;
          end else begin
            wait_cnt_q <= wait_cnt_d;
          end
        end
        RESP: begin
          if (bus.I_RSP_READY) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          psel_q      <= '0;
          penable_q   <= 1'b0;
          pwrite_q    <= 1'b0;
          paddr_q     <= '0;
          pwdata_q    <= '0;
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  // Ready is gated by reset so it reads 0 while held in reset and 1 right after release.
  assign bus.O_REQ_READY    = (state_q == IDLE) && I_PRESETN;
  assign bus.O_RSP_VALID    = rsp_valid_q;
  assign bus.O_RSP_RDATA    = rsp_rdata_q;
  assign bus.O_RSP_ERR      = rsp_err_q;
  assign bus.O_RSP_WAIT_CNT = wait_cnt_q;
  assign bus.O_PSEL         = psel_q;
  assign bus.O_PENABLE      = penable_q;
  assign bus.O_PWRITE       = pwrite_q;
  assign bus.O_PADDR        = paddr_q;
  assign bus.O_PWDATA       = pwdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: a 4-slave instance for the main traffic and a
// 3-slave instance for the decode-error boundary.
module tb_apb_master_bridge;

  logic I_PCLK = 1'b0;
  logic I_PRESETN = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 I_PCLK = ~I_PCLK;

  apb_master_bridge_if #(.NO_OF_SLAVES(4), .ADDR_WIDTH(16), .DATA_WIDTH(32), .WAIT_CNT_WIDTH(8)) bus();
  apb_master_bridge_if #(.NO_OF_SLAVES(3), .ADDR_WIDTH(16), .DATA_WIDTH(32), .WAIT_CNT_WIDTH(8)) bus3();

  apb_master_bridge #(.NO_OF_SLAVES(4), .SLAVE_ID_WIDTH(2), .ADDR_WIDTH(16),
                      .DATA_WIDTH(32), .WAIT_CNT_WIDTH(8)) dut (
    .I_PCLK(I_PCLK), .I_PRESETN(I_PRESETN), .bus(bus)
  );

  apb_master_bridge #(.NO_OF_SLAVES(3), .SLAVE_ID_WIDTH(2), .ADDR_WIDTH(16),
                      .DATA_WIDTH(32), .WAIT_CNT_WIDTH(8)) dut3 (
    .I_PCLK(I_PCLK), .I_PRESETN(I_PRESETN), .bus(bus3)
  );

  task automatic tick();
    @(posedge I_PCLK);
    #1;
  endtask

  task automatic test_reset();
    bus.I_REQ_VALID = 0; bus.I_REQ_WRITE = 0; bus.I_REQ_ADDR = '0; bus.I_REQ_WDATA = '0;
    bus.I_RSP_READY = 0; bus.I_PREADY = 0; bus.I_PSLVERR = 0; bus.I_PRDATA = '0;
    bus3.I_REQ_VALID = 0; bus3.I_REQ_WRITE = 0; bus3.I_REQ_ADDR = '0; bus3.I_REQ_WDATA = '0;
    bus3.I_RSP_READY = 0; bus3.I_PREADY = 0; bus3.I_PSLVERR = 0; bus3.I_PRDATA = '0;
    I_PRESETN = 0;
    tick(); tick();
    n_cmp++;
    if (bus.O_REQ_READY !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", bus.O_REQ_READY); end
    n_cmp++;
    if ({bus.O_PSEL, bus.O_PENABLE, bus.O_PWRITE, bus.O_PADDR, bus.O_PWDATA} !== '0) begin
      n_err++; $display("FAIL reset_apb: psel=%b pen=%b pwr=%b paddr=%h pwdata=%h want all 0",
                        bus.O_PSEL, bus.O_PENABLE, bus.O_PWRITE, bus.O_PADDR, bus.O_PWDATA);
    end
    n_cmp++;
    if ({bus.O_RSP_VALID, bus.O_RSP_RDATA, bus.O_RSP_ERR, bus.O_RSP_WAIT_CNT} !== '0) begin
      n_err++; $display("FAIL reset_rsp: valid=%b rdata=%h err=%b wait=%0d want all 0",
                        bus.O_RSP_VALID, bus.O_RSP_RDATA, bus.O_RSP_ERR, bus.O_RSP_WAIT_CNT);
    end
    I_PRESETN = 1;
    #1;
    n_cmp++;
    if (bus.O_REQ_READY !== 1'b1) begin n_err++; $display("FAIL release_ready: got %b want 1", bus.O_REQ_READY); end
    $display("test_reset done");
  endtask

  // Starts immediately after reset release, so acceptance happens on the first rising edge.
  task automatic test_read();
    bus.I_REQ_VALID = 1; bus.I_REQ_WRITE = 0; bus.I_REQ_ADDR = 16'h4010; bus.I_REQ_WDATA = '0;
    tick();
    bus.I_REQ_VALID = 0;
    n_cmp++;
    if (bus.O_PSEL !== 4'b0010 || bus.O_PENABLE !== 1'b0 || bus.O_PADDR !== 16'h4010 || bus.O_PWRITE !== 1'b0) begin
      n_err++; $display("FAIL read_setup: psel=%b pen=%b paddr=%h pwr=%b want 0010/0/4010/0",
                        bus.O_PSEL, bus.O_PENABLE, bus.O_PADDR, bus.O_PWRITE);
    end
    n_cmp++;
    if (bus.O_REQ_READY !== 1'b0) begin n_err++; $display("FAIL read_ready_busy: got %b want 0", bus.O_REQ_READY); end
    bus.I_PREADY = 1; bus.I_PRDATA = 32'hDEADBEEF;
    tick();
    n_cmp++;
    if (bus.O_PSEL !== 4'b0010 || bus.O_PENABLE !== 1'b1 || bus.O_RSP_VALID !== 1'b0) begin
      n_err++; $display("FAIL read_access: psel=%b pen=%b rspv=%b want 0010/1/0",
                        bus.O_PSEL, bus.O_PENABLE, bus.O_RSP_VALID);
    end
    tick();
    n_cmp++;
    if (bus.O_RSP_VALID !== 1'b1 || bus.O_RSP_RDATA !== 32'hDEADBEEF || bus.O_RSP_ERR !== 1'b0 || bus.O_RSP_WAIT_CNT !== 8'd0) begin
      n_err++; $display("FAIL read_rsp: valid=%b rdata=%h err=%b wait=%0d want 1/deadbeef/0/0",
                        bus.O_RSP_VALID, bus.O_RSP_RDATA, bus.O_RSP_ERR, bus.O_RSP_WAIT_CNT);
    end
    n_cmp++;
    if (bus.O_PSEL !== 4'b0000 || bus.O_PENABLE !== 1'b0 || bus.O_PADDR !== 16'h0000) begin
      n_err++; $display("FAIL read_apb_idle: psel=%b pen=%b paddr=%h want 0/0/0", bus.O_PSEL, bus.O_PENABLE, bus.O_PADDR);
    end
    bus.I_RSP_READY = 1; bus.I_PREADY = 0; bus.I_PRDATA = '0;
    tick();
    bus.I_RSP_READY = 0;
    n_cmp++;
    if (bus.O_RSP_VALID !== 1'b0 || bus.O_REQ_READY !== 1'b1) begin
      n_err++; $display("FAIL read_done: rspv=%b ready=%b want 0/1", bus.O_RSP_VALID, bus.O_REQ_READY);
    end
    $display("test_read done");
  endtask

  task automatic test_write_wait();
    bus.I_REQ_VALID = 1; bus.I_REQ_WRITE = 1; bus.I_REQ_ADDR = 16'h0004; bus.I_REQ_WDATA = 32'h12345678;
    bus.I_PRDATA = 32'hFFFF0000;
    tick();
    bus.I_REQ_VALID = 0; bus.I_REQ_WDATA = 32'h0; bus.I_PREADY = 0;
    n_cmp++;
    if (bus.O_PSEL !== 4'b0001 || bus.O_PWRITE !== 1'b1 || bus.O_PWDATA !== 32'h12345678) begin
      n_err++; $display("FAIL write_setup: psel=%b pwr=%b pwdata=%h want 0001/1/12345678",
                        bus.O_PSEL, bus.O_PWRITE, bus.O_PWDATA);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (bus.O_PENABLE !== 1'b1 || bus.O_PWDATA !== 32'h12345678 || bus.O_PSEL !== 4'b0001) begin
        n_err++; $display("FAIL write_hold[%0d]: pen=%b pwdata=%h psel=%b want 1/12345678/0001",
                          i, bus.O_PENABLE, bus.O_PWDATA, bus.O_PSEL);
      end
    end
    tick();
    n_cmp++;
    if (bus.O_RSP_WAIT_CNT !== 8'd3 || bus.O_PENABLE !== 1'b1) begin
      n_err++; $display("FAIL write_live_wait: wait=%0d pen=%b want 3/1", bus.O_RSP_WAIT_CNT, bus.O_PENABLE);
    end
    bus.I_PREADY = 1;
    tick();
    bus.I_PREADY = 0;
    n_cmp++;
    if (bus.O_RSP_VALID !== 1'b1 || bus.O_RSP_RDATA !== 32'h0 || bus.O_RSP_WAIT_CNT !== 8'd3 || bus.O_RSP_ERR !== 1'b0) begin
      n_err++; $display("FAIL write_rsp: valid=%b rdata=%h wait=%0d err=%b want 1/0/3/0",
                        bus.O_RSP_VALID, bus.O_RSP_RDATA, bus.O_RSP_WAIT_CNT, bus.O_RSP_ERR);
    end
    bus.I_RSP_READY = 1;
    tick();
    bus.I_RSP_READY = 0;
    $display("test_write_wait done");
  endtask

  task automatic test_slverr_hold();
    bus.I_REQ_VALID = 1; bus.I_REQ_WRITE = 0; bus.I_REQ_ADDR = 16'h8000;
    tick();
    bus.I_REQ_VALID = 0;
    bus.I_PREADY = 1; bus.I_PSLVERR = 1; bus.I_PRDATA = 32'hA5A5A5A5;
    tick();
    tick();
    // Slave inputs wiggle during RESP; the captured response must not follow them.
    bus.I_PREADY = 0; bus.I_PSLVERR = 0; bus.I_PRDATA = 32'h0;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (bus.O_RSP_VALID !== 1'b1 || bus.O_RSP_ERR !== 1'b1 || bus.O_RSP_RDATA !== 32'hA5A5A5A5 || bus.O_REQ_READY !== 1'b0) begin
        n_err++; $display("FAIL slverr_hold[%0d]: valid=%b err=%b rdata=%h ready=%b want 1/1/a5a5a5a5/0",
                          i, bus.O_RSP_VALID, bus.O_RSP_ERR, bus.O_RSP_RDATA, bus.O_REQ_READY);
      end
      tick();
    end
    bus.I_RSP_READY = 1;
    bus.I_REQ_VALID = 1; bus.I_REQ_WRITE = 0; bus.I_REQ_ADDR = 16'h0000;
    n_cmp++;
    if (bus.O_REQ_READY !== 1'b0) begin n_err++; $display("FAIL consume_ready: got %b want 0", bus.O_REQ_READY); end
    tick();
    bus.I_RSP_READY = 0;
    n_cmp++;
    if (bus.O_RSP_VALID !== 1'b0 || bus.O_PSEL !== 4'b0000 || bus.O_REQ_READY !== 1'b1) begin
      n_err++; $display("FAIL consume_no_accept: rspv=%b psel=%b ready=%b want 0/0000/1",
                        bus.O_RSP_VALID, bus.O_PSEL, bus.O_REQ_READY);
    end
    tick();
    bus.I_REQ_VALID = 0;
    n_cmp++;
    if (bus.O_PSEL !== 4'b0001) begin n_err++; $display("FAIL accept_after_consume: psel=%b want 0001", bus.O_PSEL); end
    bus.I_PREADY = 1;
    tick(); tick();
    bus.I_PREADY = 0; bus.I_RSP_READY = 1;
    tick();
    bus.I_RSP_READY = 0;
    $display("test_slverr_hold done");
  endtask

  task automatic test_decode_err();
    bus3.I_REQ_VALID = 1; bus3.I_REQ_WRITE = 1; bus3.I_REQ_ADDR = 16'hC000; bus3.I_REQ_WDATA = 32'hFFFFFFFF;
    n_cmp++;
    if (bus3.O_REQ_READY !== 1'b1) begin n_err++; $display("FAIL dec_ready: got %b want 1", bus3.O_REQ_READY); end
    tick();
    bus3.I_REQ_VALID = 0;
    n_cmp++;
    if (bus3.O_RSP_VALID !== 1'b1 || bus3.O_RSP_ERR !== 1'b1 || bus3.O_RSP_RDATA !== 32'h0 || bus3.O_RSP_WAIT_CNT !== 8'd0) begin
      n_err++; $display("FAIL dec_rsp: valid=%b err=%b rdata=%h wait=%0d want 1/1/0/0",
                        bus3.O_RSP_VALID, bus3.O_RSP_ERR, bus3.O_RSP_RDATA, bus3.O_RSP_WAIT_CNT);
    end
    n_cmp++;
    if (bus3.O_PSEL !== 3'b000 || bus3.O_PENABLE !== 1'b0 || bus3.O_PWDATA !== 32'h0) begin
      n_err++; $display("FAIL dec_no_apb: psel=%b pen=%b pwdata=%h want 000/0/0", bus3.O_PSEL, bus3.O_PENABLE, bus3.O_PWDATA);
    end
    bus3.I_RSP_READY = 1;
    tick();
    bus3.I_RSP_READY = 0;
    n_cmp++;
    if (bus3.O_RSP_VALID !== 1'b0 || bus3.O_REQ_READY !== 1'b1) begin
      n_err++; $display("FAIL dec_done: rspv=%b ready=%b want 0/1", bus3.O_RSP_VALID, bus3.O_REQ_READY);
    end
    // Highest valid index on the 3-slave instance.
    bus3.I_REQ_VALID = 1; bus3.I_REQ_WRITE = 0; bus3.I_REQ_ADDR = 16'h8000;
    tick();
    bus3.I_REQ_VALID = 0;
    n_cmp++;
    if (bus3.O_PSEL !== 3'b100) begin n_err++; $display("FAIL dec_edge_psel: psel=%b want 100", bus3.O_PSEL); end
    bus3.I_PREADY = 1; bus3.I_PRDATA = 32'h00C0FFEE;
    tick(); tick();
    bus3.I_PREADY = 0;
    n_cmp++;
    if (bus3.O_RSP_VALID !== 1'b1 || bus3.O_RSP_ERR !== 1'b0 || bus3.O_RSP_RDATA !== 32'h00C0FFEE) begin
      n_err++; $display("FAIL dec_edge_rsp: valid=%b err=%b rdata=%h want 1/0/00c0ffee",
                        bus3.O_RSP_VALID, bus3.O_RSP_ERR, bus3.O_RSP_RDATA);
    end
    bus3.I_RSP_READY = 1;
    tick();
    bus3.I_RSP_READY = 0;
    $display("test_decode_err done");
  endtask

  task automatic test_back_to_back();
    bus.I_REQ_VALID = 1; bus.I_REQ_WRITE = 1; bus.I_REQ_ADDR = 16'hC008; bus.I_REQ_WDATA = 32'hCAFEF00D;
    tick();
    bus.I_REQ_VALID = 0;
    n_cmp++;
    if (bus.O_PSEL !== 4'b1000 || bus.O_PADDR !== 16'hC008 || bus.O_PWDATA !== 32'hCAFEF00D) begin
      n_err++; $display("FAIL b2b_w_setup: psel=%b paddr=%h pwdata=%h want 1000/c008/cafef00d",
                        bus.O_PSEL, bus.O_PADDR, bus.O_PWDATA);
    end
    bus.I_PREADY = 1;
    tick(); tick();
    n_cmp++;
    if (bus.O_RSP_VALID !== 1'b1 || bus.O_RSP_RDATA !== 32'h0) begin
      n_err++; $display("FAIL b2b_w_rsp: valid=%b rdata=%h want 1/0", bus.O_RSP_VALID, bus.O_RSP_RDATA);
    end
    bus.I_RSP_READY = 1;
    tick();
    bus.I_RSP_READY = 0;
    bus.I_REQ_VALID = 1; bus.I_REQ_WRITE = 0; bus.I_REQ_ADDR = 16'h4000; bus.I_REQ_WDATA = 32'h0;
    tick();
    bus.I_REQ_VALID = 0; bus.I_PRDATA = 32'h00001234;
    n_cmp++;
    if (bus.O_PSEL !== 4'b0010 || bus.O_PWRITE !== 1'b0 || bus.O_PADDR !== 16'h4000) begin
      n_err++; $display("FAIL b2b_r_setup: psel=%b pwr=%b paddr=%h want 0010/0/4000", bus.O_PSEL, bus.O_PWRITE, bus.O_PADDR);
    end
    tick(); tick();
    bus.I_PREADY = 0;
    n_cmp++;
    if (bus.O_RSP_VALID !== 1'b1 || bus.O_RSP_RDATA !== 32'h00001234) begin
      n_err++; $display("FAIL b2b_r_rsp: valid=%b rdata=%h want 1/00001234", bus.O_RSP_VALID, bus.O_RSP_RDATA);
    end
    bus.I_RSP_READY = 1;
    tick();
    bus.I_RSP_READY = 0;
    $display("test_back_to_back done");
  endtask

  task automatic test_reset_mid();
    bus.I_REQ_VALID = 1; bus.I_REQ_WRITE = 1; bus.I_REQ_ADDR = 16'h8004; bus.I_REQ_WDATA = 32'h55AA55AA;
    tick();
    bus.I_REQ_VALID = 0; bus.I_PREADY = 0;
    tick(); tick();
    n_cmp++;
    if (bus.O_PENABLE !== 1'b1 || bus.O_PSEL !== 4'b0100) begin
      n_err++; $display("FAIL rstmid_access: pen=%b psel=%b want 1/0100", bus.O_PENABLE, bus.O_PSEL);
    end
    I_PRESETN = 0;
    #1;
    n_cmp++;
    if ({bus.O_PSEL, bus.O_PENABLE, bus.O_PWRITE, bus.O_PADDR, bus.O_PWDATA} !== '0) begin
      n_err++; $display("FAIL rstmid_apb: psel=%b pen=%b pwr=%b paddr=%h pwdata=%h want all 0",
                        bus.O_PSEL, bus.O_PENABLE, bus.O_PWRITE, bus.O_PADDR, bus.O_PWDATA);
    end
    n_cmp++;
    if ({bus.O_REQ_READY, bus.O_RSP_VALID, bus.O_RSP_WAIT_CNT} !== '0) begin
      n_err++; $display("FAIL rstmid_rsp: ready=%b rspv=%b wait=%0d want 0/0/0",
                        bus.O_REQ_READY, bus.O_RSP_VALID, bus.O_RSP_WAIT_CNT);
    end
    tick();
    I_PRESETN = 1; bus.I_PREADY = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (bus.O_RSP_VALID !== 1'b0 || bus.O_PSEL !== 4'b0000 || bus.O_REQ_READY !== 1'b1) begin
        n_err++; $display("FAIL rstmid_after[%0d]: rspv=%b psel=%b ready=%b want 0/0000/1",
                          i, bus.O_RSP_VALID, bus.O_PSEL, bus.O_REQ_READY);
      end
    end
    bus.I_PREADY = 0;
    $display("test_reset_mid done");
  endtask

  task automatic test_saturate();
    bus.I_REQ_VALID = 1; bus.I_REQ_WRITE = 0; bus.I_REQ_ADDR = 16'h0000;
    tick();
    bus.I_REQ_VALID = 0; bus.I_PREADY = 0;
    repeat (101) tick();
    n_cmp++;
    if (bus.O_RSP_WAIT_CNT !== 8'd100) begin n_err++; $display("FAIL sat_mid: wait=%0d want 100", bus.O_RSP_WAIT_CNT); end
    repeat (200) tick();
    bus.I_PREADY = 1;
    tick();
    bus.I_PREADY = 0;
    n_cmp++;
    if (bus.O_RSP_VALID !== 1'b1 || bus.O_RSP_WAIT_CNT !== 8'd255) begin
      n_err++; $display("FAIL sat_rsp: valid=%b wait=%0d want 1/255", bus.O_RSP_VALID, bus.O_RSP_WAIT_CNT);
    end
    bus.I_RSP_READY = 1;
    tick();
    bus.I_RSP_READY = 0;
    $display("test_saturate done");
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_wait();
    test_slverr_hold();
    test_decode_err();
    test_back_to_back();
    test_reset_mid();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
